// File: rtl/axil_xbar.sv
// AXI-Lite 1:N crossbar. Address decode, one outstanding read and one outstanding write.
// Define AXIL_XBAR_DECERR_EN to answer unmapped addresses with DECERR instead of routing them to slave 0.
module axil_xbar #(
  parameter int unsigned       SLAVE_NUM = 2,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] SLAVE_BASE [SLAVE_NUM] = '{32'ha00003f8, 32'h80000000},
  parameter logic [ADDR_W-1:0] SLAVE_SIZE [SLAVE_NUM] = '{32'h4, 32'h08000000}
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ADDR_W-1:0]                   m_araddr,
  input  logic [ADDR_W-1:0]                   m_awaddr,
  input  logic                                m_arvalid,
  input  logic                                m_awvalid,
  input  logic                                m_wvalid,
  input  logic                                m_rready,
  input  logic                                m_bready,
  input  logic [DATA_W-1:0]                   m_wdata,
  input  logic [DATA_W/8-1:0]                 m_wstrb,
  output logic                                m_arready,
  output logic                                m_awready,
  output logic                                m_wready,
  output logic                                m_rvalid,
  output logic                                m_bvalid,
  output logic [DATA_W-1:0]                   m_rdata,
  output logic [1:0]                          m_rresp,
  output logic [1:0]                          m_bresp,
  output logic [SLAVE_NUM-1:0][ADDR_W-1:0]    s_araddr,
  output logic [SLAVE_NUM-1:0][ADDR_W-1:0]    s_awaddr,
  output logic [SLAVE_NUM-1:0][DATA_W-1:0]    s_wdata,
  output logic [SLAVE_NUM-1:0][DATA_W/8-1:0]  s_wstrb,
  output logic [SLAVE_NUM-1:0]                s_arvalid,
  output logic [SLAVE_NUM-1:0]                s_awvalid,
  output logic [SLAVE_NUM-1:0]                s_wvalid,
  output logic [SLAVE_NUM-1:0]                s_rready,
  output logic [SLAVE_NUM-1:0]                s_bready,
  input  logic [SLAVE_NUM-1:0]                s_arready,
  input  logic [SLAVE_NUM-1:0]                s_awready,
  input  logic [SLAVE_NUM-1:0]                s_wready,
  input  logic [SLAVE_NUM-1:0]                s_rvalid,
  input  logic [SLAVE_NUM-1:0]                s_bvalid,
  input  logic [SLAVE_NUM-1:0][DATA_W-1:0]    s_rdata,
  input  logic [SLAVE_NUM-1:0][1:0]           s_rresp,
  input  logic [SLAVE_NUM-1:0][1:0]           s_bresp
);

  localparam int unsigned IDX_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

`ifdef AXIL_XBAR_DECERR_EN
  typedef enum logic [1:0] {RD_IDLE, RD_RESP, RD_ERR} rd_state_t;
  typedef enum logic [2:0] {WR_IDLE, WR_DATA, WR_ADDR, WR_RESP, WR_ERR} wr_state_t;
`else
  typedef enum logic [1:0] {RD_IDLE, RD_RESP} rd_state_t;
  typedef enum logic [2:0] {WR_IDLE, WR_DATA, WR_ADDR, WR_RESP} wr_state_t;
`endif

  rd_state_t              r_rd_state, w_rd_next;
  wr_state_t              r_wr_state, w_wr_next;
  logic [IDX_W-1:0]       r_rd_idx, w_rd_idx_next;
  logic [IDX_W-1:0]       r_wr_idx, w_wr_idx_next;
  logic [SLAVE_NUM-1:0]   w_ar_hit, w_aw_hit;
  logic [IDX_W-1:0]       w_ar_sel, w_aw_sel;

  // Bounds are compared one bit wider so a region ending at 2^ADDR_W does not wrap.
  function automatic logic [SLAVE_NUM-1:0] f_hit(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] lo, hi;
    f_hit = '0;
    for (int unsigned j = 0; j < SLAVE_NUM; j++) begin
      lo = {1'b0, SLAVE_BASE[j]};
      hi = lo + {1'b0, SLAVE_SIZE[j]};
      f_hit[j] = ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    end
  endfunction

  // Scanning downward lets the lowest matching region win; no hit falls back to 0.
  function automatic logic [IDX_W-1:0] f_sel(input logic [SLAVE_NUM-1:0] h);
    f_sel = '0;
    for (int unsigned j = SLAVE_NUM; j > 0; j--)
      if (h[j-1]) f_sel = IDX_W'(j-1);
  endfunction

  assign w_ar_hit = f_hit(m_araddr);
  assign w_aw_hit = f_hit(m_awaddr);
  assign w_ar_sel = f_sel(w_ar_hit);
  assign w_aw_sel = f_sel(w_aw_hit);

  assign s_araddr = {SLAVE_NUM{m_araddr}};
  assign s_awaddr = {SLAVE_NUM{m_awaddr}};
  assign s_wdata  = {SLAVE_NUM{m_wdata}};
  assign s_wstrb  = {SLAVE_NUM{m_wstrb}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_state <= RD_IDLE;
      r_wr_state <= WR_IDLE;
      r_rd_idx   <= '0;
      r_wr_idx   <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      r_wr_state <= w_wr_next;
      r_rd_idx   <= w_rd_idx_next;
      r_wr_idx   <= w_wr_idx_next;
    end
  end

  always_comb begin
    w_rd_next     = r_rd_state;
    w_rd_idx_next = r_rd_idx;
    s_arvalid     = '0;
    s_rready      = '0;
    m_arready     = 1'b0;
    m_rvalid      = 1'b0;
    m_rdata       = '0;
    m_rresp       = '0;
    case (r_rd_state)
      RD_IDLE: begin
`ifdef AXIL_XBAR_DECERR_EN
        if (!(|w_ar_hit)) begin
          m_arready = m_arvalid;
          if (m_arvalid) w_rd_next = RD_ERR;
        end else
`endif
        begin
          s_arvalid[w_ar_sel] = m_arvalid;
          m_arready           = s_arready[w_ar_sel];
          if (m_arvalid && s_arready[w_ar_sel]) begin
            w_rd_next     = RD_RESP;
            w_rd_idx_next = w_ar_sel;
          end
        end
      end
      RD_RESP: begin
        s_rready[r_rd_idx] = m_rready;
        m_rvalid           = s_rvalid[r_rd_idx];
        m_rdata            = s_rdata[r_rd_idx];
        m_rresp            = s_rresp[r_rd_idx];
        if (m_rready && s_rvalid[r_rd_idx]) w_rd_next = RD_IDLE;
      end
`ifdef AXIL_XBAR_DECERR_EN
      RD_ERR: begin
        m_rvalid = 1'b1;
        m_rresp  = 2'b11;
        if (m_rready) w_rd_next = RD_IDLE;
      end
`endif
      default: w_rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    w_wr_next     = r_wr_state;
    w_wr_idx_next = r_wr_idx;
    s_awvalid     = '0;
    s_wvalid      = '0;
    s_bready      = '0;
    m_awready     = 1'b0;
    m_wready      = 1'b0;
    m_bvalid      = 1'b0;
    m_bresp       = '0;
    case (r_wr_state)
      WR_IDLE: begin
        if (m_awvalid) begin
`ifdef AXIL_XBAR_DECERR_EN
          // Unmapped writes are swallowed only once both AW and W are present.
          if (!(|w_aw_hit)) begin
            m_awready = m_wvalid;
            m_wready  = m_wvalid;
            if (m_wvalid) w_wr_next = WR_ERR;
          end else
`endif
          begin
            s_awvalid[w_aw_sel] = 1'b1;
            s_wvalid[w_aw_sel]  = m_wvalid;
            m_awready           = s_awready[w_aw_sel];
            m_wready            = s_wready[w_aw_sel];
            if (s_awready[w_aw_sel] || (m_wvalid && s_wready[w_aw_sel]))
              w_wr_idx_next = w_aw_sel;
            if (s_awready[w_aw_sel] && m_wvalid && s_wready[w_aw_sel])
              w_wr_next = WR_RESP;
            else if (s_awready[w_aw_sel])
              w_wr_next = WR_DATA;
            else if (m_wvalid && s_wready[w_aw_sel])
              w_wr_next = WR_ADDR;
          end
        end
      end
      WR_DATA: begin
        s_wvalid[r_wr_idx] = m_wvalid;
        m_wready           = s_wready[r_wr_idx];
        if (m_wvalid && s_wready[r_wr_idx]) w_wr_next = WR_RESP;
      end
      WR_ADDR: begin
        s_awvalid[r_wr_idx] = m_awvalid;
        m_awready           = s_awready[r_wr_idx];
        if (m_awvalid && s_awready[r_wr_idx]) w_wr_next = WR_RESP;
      end
      WR_RESP: begin
        s_bready[r_wr_idx] = m_bready;
        m_bvalid           = s_bvalid[r_wr_idx];
        m_bresp            = s_bresp[r_wr_idx];
        if (m_bready && s_bvalid[r_wr_idx]) w_wr_next = WR_IDLE;
      end
`ifdef AXIL_XBAR_DECERR_EN
      WR_ERR: begin
        m_bvalid = 1'b1;
        m_bresp  = 2'b11;
        if (m_bready) w_wr_next = WR_IDLE;
      end
`endif
      default: w_wr_next = WR_IDLE;
    endcase
  end

endmodule

// File: doc/axil_xbar.md
AXIL_XBAR -- requirements
Module: axil_xbar

Interface
REQ-001 The block SHALL have parameter SLAVE_NUM, default 2, the number of slave ports (1..16).
REQ-002 The block SHALL have parameter ADDR_W, default 32, the address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, the data width; write strobe width is DATA_W/8.
REQ-004 The block SHALL have parameter SLAVE_BASE[SLAVE_NUM], default '{32'ha00003f8, 32'h80000000}, the region base addresses.
REQ-005 The block SHALL have parameter SLAVE_SIZE[SLAVE_NUM], default '{32'h4, 32'h08000000}, the region sizes in bytes.
REQ-006 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock, all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- m_araddr/m_awaddr  in  ADDR_W  master read/write address
- m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready  in  1  master handshake inputs
- m_wdata  in  DATA_W  write data; m_wstrb  in  DATA_W/8  byte strobes
- m_arready, m_awready, m_wready, m_rvalid, m_bvalid  out  1  master handshake outputs
- m_rdata  out  DATA_W  read data; m_rresp, m_bresp  out  2  responses
- s_araddr/s_awaddr  out  [SLAVE_NUM][ADDR_W]  addresses broadcast to every slave
- s_wdata  out  [SLAVE_NUM][DATA_W]; s_wstrb  out  [SLAVE_NUM][DATA_W/8]  broadcast
- s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready  out  [SLAVE_NUM]  gated per slave
- s_arready, s_awready, s_wready, s_rvalid, s_bvalid  in  [SLAVE_NUM]
- s_rdata  in  [SLAVE_NUM][DATA_W]; s_rresp, s_bresp  in  [SLAVE_NUM][2]

Function
REQ-007 Decode SHALL be hit[j] = (addr >= SLAVE_BASE[j]) && (addr < SLAVE_BASE[j]+SLAVE_SIZE[j]), computed at ADDR_W+1 bits so a region ending at 2^ADDR_W does not wrap; on overlap the lowest j SHALL win.
REQ-008 The read FSM SHALL have states RD_IDLE, RD_RESP and RD_ERR, with at most one read outstanding.
REQ-009 In RD_IDLE, s_arvalid[sel] SHALL equal m_arvalid and m_arready SHALL equal s_arready[sel]; when AR completes, sel SHALL be latched into rd_idx and the FSM SHALL go to RD_RESP.
REQ-010 In RD_RESP, m_arready SHALL be 0, all s_arvalid SHALL be 0, m_rvalid/m_rdata/m_rresp SHALL come combinationally from s_*[rd_idx], and s_rready[rd_idx] SHALL equal m_rready; on R handshake the FSM SHALL return to RD_IDLE.
REQ-011 A change of m_araddr while in RD_RESP SHALL NOT alter routing.
REQ-012 The write FSM SHALL have states WR_IDLE, WR_DATA, WR_ADDR, WR_RESP and WR_ERR, with at most one write outstanding.
REQ-013 In WR_IDLE, while m_awvalid=1, AW and W SHALL both be forwarded to the decoded slave, and wr_idx SHALL be latched at the first AW or W handshake.
REQ-014 While m_awvalid=0, s_wvalid SHALL be 0 and m_wready SHALL be 0.
REQ-015 The write FSM SHALL transition as follows: AW and W in the same cycle -> WR_RESP; AW only -> WR_DATA; W only -> WR_ADDR.
REQ-016 WR_DATA SHALL forward only W to wr_idx, and WR_ADDR SHALL forward only AW to wr_idx; each SHALL go to WR_RESP on its handshake.
REQ-017 In WR_RESP, B SHALL be routed from wr_idx, and the FSM SHALL return to WR_IDLE on the B handshake.
REQ-018 Read and write FSMs SHALL be independent and operate concurrently, including to the same slave.
REQ-019 Unselected slaves SHALL see valid=0 and ready=0 on every channel.

Reset
REQ-020 While reset=1, both FSMs SHALL go to their IDLE states and rd_idx and wr_idx SHALL clear to 0.
REQ-021 In the cycle after reset=1 is sampled, all m_* valid/ready outputs and all s_* valid/ready outputs SHALL be 0; m_rdata, m_rresp and m_bresp SHALL be 0.
REQ-022 A reset asserted mid-transaction SHALL abandon that transaction without generating a response.

Configuration
REQ-023 Macro AXIL_XBAR_DECERR_EN defined: an address with no hit SHALL be accepted by the block itself (m_arready=1 or m_awready=m_wready=1) and the FSM SHALL enter RD_ERR or WR_ERR.
REQ-024 With AXIL_XBAR_DECERR_EN defined, RD_ERR and WR_ERR SHALL drive m_rvalid or m_bvalid = 1, resp = 2'b11 and m_rdata = 0 from the next cycle, and return to IDLE on the handshake; no slave SHALL see the transaction.
REQ-025 Macro AXIL_XBAR_DECERR_EN undefined: a no-hit address SHALL route to slave 0, and the RD_ERR/WR_ERR states SHALL NOT exist.

Verification
REQ-026 Read 0x80000010, slave1 arready after 2 cycles, rdata 0xDEADBEEF -> only s_arvalid[1] asserted; m_rdata=0xDEADBEEF, m_rresp=0.
REQ-027 Write 0xa00003f8, data 0x41: AW accepted at t, W accepted at t+3 -> WR_DATA for 3 cycles; slave0 gets wdata 0x41; m_bvalid after slave0 bvalid.
REQ-028 Read 0x80000000 followed by a write 0xa00003f8 while the read awaits R -> both complete in parallel with responses routed correctly.
REQ-029 With DECERR_EN, read 0x00001000 -> m_arready=1 at t, m_rvalid=1 with rresp=2'b11 and rdata=0 at t+1, and no s_arvalid is asserted; without DECERR_EN, s_arvalid[0] is asserted instead.
REQ-030 Reset asserted while in RD_RESP -> next cycle RD_IDLE with all valids 0, and a subsequent read completes normally.
REQ-031 Hold m_rready=0 for 5 cycles during RD_RESP while m_araddr changes -> m_rvalid and m_rdata remain stable from rd_idx.
